// File: rtl/io_channel_pkg.sv
// ============================================================================
// Module   : io_channel_pkg
// Brief    : Shared FSM states, condition codes and address types for io_channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_channel_pkg;

    localparam int ADDR_W = 17;

    typedef logic [32-ADDR_W:31] word_addr_t;
    typedef logic [0:31]         word_t;
    typedef logic [0:3]          cc_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam cc_t CC_OK   = 4'b0000;
    localparam cc_t CC_BUSY = 4'b1000;
    localparam cc_t CC_ZERO = 4'b0100;
    localparam cc_t CC_HALT = 4'b0010;

    // Word addresses wrap silently at the top of the 17-bit space.
    function automatic word_addr_t addr_inc(input word_addr_t a);
        return a + word_addr_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_channel_if.sv
// ============================================================================
// Module   : io_channel_if
// Brief    : Command, memory-port and device-stream signals of io_channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_channel_if;
    import io_channel_pkg::*;

    logic        sio;
    word_addr_t  sio_addr;
    logic [15:0] sio_count;
    logic        sio_dir;
    logic        hio;
    logic        running;
    cc_t         cc;

    logic        mem_grant;
    word_addr_t  mem_address;
    logic [0:3]  mem_wr_en;
    word_t       mem_data_out;
    word_t       mem_data_in;

    word_t       dev_out_data;
    logic        dev_out_valid;
    logic        dev_out_ready;
    word_t       dev_in_data;
    logic        dev_in_valid;
    logic        dev_in_ready;

    modport master (
        output sio, sio_addr, sio_count, sio_dir, hio,
        output mem_grant, mem_data_in, dev_out_ready, dev_in_data, dev_in_valid,
        input  running, cc, mem_address, mem_wr_en, mem_data_out,
        input  dev_out_data, dev_out_valid, dev_in_ready
    );

    modport slave (
        input  sio, sio_addr, sio_count, sio_dir, hio,
        input  mem_grant, mem_data_in, dev_out_ready, dev_in_data, dev_in_valid,
        output running, cc, mem_address, mem_wr_en, mem_data_out,
        output dev_out_data, dev_out_valid, dev_in_ready
    );

endinterface

`default_nettype wire

// File: rtl/io_channel_fifo.sv
// ============================================================================
// Module   : io_channel_fifo
// Brief    : Synchronous word FIFO, registered wrap-bit pointers, flush input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_channel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  last_o
);

    localparam int            PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] ONE_LEFT = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign last_o  = ((wr_ptr_q - rd_ptr_q) == ONE_LEFT);

    // Full gates the push before any same-cycle pop is considered.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_channel.sv
// ============================================================================
// Module   : io_channel
// Brief    : Word-block channel between memory and a device stream.
//            Halt I/O support is compiled in with IOC_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_channel
    import io_channel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    io_channel_if.slave bus
);

    logic [1:0]  state_q, state_d;
    word_addr_t  addr_q, addr_d;
    logic [15:0] count_q, count_d;
    cc_t         cc_q, cc_d;

    logic        halt_req;
    logic        fetch_beat;
    logic        store_open;
    logic        store_beat;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_last;
    logic        fifo_pop;
    word_t       fifo_rdata;

`ifdef IOC_HALT_EN
    assign halt_req = reset && bus.hio && (state_q != ST_IDLE);
`else
    logic unused_hio;
    assign unused_hio = bus.hio;
    assign halt_req   = 1'b0;
`endif

    // Memory beats are qualified by reset so the reset edge never writes.
    assign fetch_beat = reset && !halt_req && (state_q == ST_FETCH) &&
                        bus.mem_grant && !fifo_full && (count_q != 16'd0);
    assign store_open = reset && !halt_req && (state_q == ST_STORE) &&
                        (count_q != 16'd0);
    assign store_beat = bus.dev_in_ready && bus.dev_in_valid;

    assign bus.dev_in_ready  = store_open && bus.mem_grant;
    assign bus.mem_address   = (fetch_beat || store_beat) ? addr_q : '0;
    assign bus.mem_wr_en     = store_beat ? 4'b1111 : 4'b0000;
    assign bus.mem_data_out  = store_beat ? bus.dev_in_data : '0;
    assign bus.dev_out_valid = !fifo_empty;
    assign bus.dev_out_data  = fifo_rdata;
    assign bus.running       = (state_q != ST_IDLE);
    assign bus.cc            = cc_q;

    assign fifo_pop = !fifo_empty && bus.dev_out_ready;

    io_channel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (halt_req),
        .push_i  (fetch_beat),
        .wdata_i (bus.mem_data_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .last_o  (fifo_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        cc_d    = cc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sio) begin
                    addr_d  = bus.sio_addr;
                    count_d = bus.sio_count;
                    if (bus.sio_count == 16'd0) begin
                        cc_d = CC_ZERO;
                    end else begin
                        cc_d    = CC_OK;
                        state_d = bus.sio_dir ? ST_STORE : ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_beat) begin
                    addr_d  = addr_inc(addr_q);
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) state_d = ST_DRAIN;
                end
            end
            ST_STORE: begin
                if (store_beat) begin
                    addr_d  = addr_inc(addr_q);
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d = ST_IDLE;
                        cc_d    = CC_OK;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && fifo_last) begin
                    state_d = ST_IDLE;
                    cc_d    = CC_OK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A rejected command only reports busy; the transfer keeps going.
        if (bus.sio && (state_q != ST_IDLE)) cc_d = CC_BUSY;
        if (halt_req) begin
            state_d = ST_IDLE;
            count_d = '0;
            cc_d    = CC_HALT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            cc_q    <= CC_OK;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            cc_q    <= cc_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/io_channel.md
IO_CHANNEL -- requirements
Module: io_channel

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2; memory-to-device word buffer depth.
REQ-002 SHALL have clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have sio  input  1  start I/O command pulse; sio_addr  input  [15:31]  start word address; sio_count  input  16  word count; sio_dir  input  1  0=memory-to-device, 1=device-to-memory.
REQ-005 SHALL have hio  input  1  halt I/O request.
REQ-006 SHALL have running  output  1  transfer in progress; cc  output  [0:3]  registered condition code.
REQ-007 SHALL have mem_grant  input  1  memory-port grant from the bus arbiter; mem_address  output  [15:31]; mem_wr_en  output  [0:3]  byte write enables; mem_data_out  output  [0:31]; mem_data_in  input  [0:31]  combinational read data for mem_address.
REQ-008 SHALL have dev_out_data  output  [0:31], dev_out_valid  output  1, dev_out_ready  input  1; dev_in_data  input  [0:31], dev_in_valid  input  1, dev_in_ready  output  1.

Function
REQ-009 SHALL implement states IDLE, FETCH (memory-to-device), STORE (device-to-memory), DRAIN (fetches done, FIFO not empty).
REQ-010 IDLE + sio: SHALL latch address/count/direction; count 0 -> stay IDLE, cc=0100 next cycle; else -> FETCH (dir 0) or STORE (dir 1), cc=0000, running=1 next cycle.
REQ-011 sio while running=1 SHALL be ignored and set cc=1000 next cycle; the active transfer is unaffected.
REQ-012 FETCH: when mem_grant=1, FIFO not full and fetch count >0, SHALL drive mem_address, capture mem_data_in into FIFO at that edge, increment address, decrement fetch count; one word per cycle maximum.
REQ-013 Memory-side outputs SHALL be combinational from state; mem_wr_en SHALL be 0000 in every state except an accepted STORE beat; mem_address SHALL be 0 when no access is issued.
REQ-014 dev_out_valid SHALL be 1 exactly when FIFO non-empty; word pops on dev_out_valid & dev_out_ready; simultaneous push and pop when full SHALL NOT be allowed (push gated by full before pop).
REQ-015 FETCH SHALL move to DRAIN when fetch count reaches 0; DRAIN SHALL move to IDLE on the cycle the last word pops, running=0 and cc=0000 next cycle.
REQ-016 STORE: dev_in_ready SHALL equal mem_grant while store count >0; on dev_in_valid & dev_in_ready SHALL drive mem_wr_en=1111, mem_data_out=dev_in_data, mem_address=current address same cycle; address +1, count -1; count 0 after beat -> IDLE, cc=0000.
REQ-017 Address increment SHALL wrap modulo 2^17 (1FFFF -> 00000) without error.
REQ-018 mem_grant=0 SHALL stall memory accesses only; FIFO output side continues.

Reset
REQ-019 reset=0 at a rising edge SHALL force IDLE, FIFO empty, counters/address 0, running=0, cc=0000, all outputs 0, including mid-transfer; no memory write SHALL occur on that edge.

Configuration
REQ-020 With IOC_HALT_EN defined: hio=1 while running SHALL flush FIFO, go to IDLE, running=0, cc=0010 next cycle; a STORE beat coincident with hio SHALL be suppressed (mem_wr_en=0000); hio in IDLE is ignored.
REQ-021 Without IOC_HALT_EN: hio SHALL be ignored entirely; transfers run to completion.

Structure
REQ-022 A shared package SHALL hold the state enumeration, cc encodings (CC_OK=0000, CC_BUSY=1000, CC_ZERO=0100, CC_HALT=0010) and the 17-bit word-address width.
REQ-023 The FIFO SHALL be a sub-module io_channel_fifo (synchronous, registered pointers, full/empty flags).

Verification
REQ-024 Memory preloaded 100..103 = A0..A3, sio addr=100 count=4 dir=0, dev_out_ready=1, grant=1 -> dev_out sequence A0,A1,A2,A3, running falls, cc=0000, no writes.
REQ-025 dir=1 addr=1FFFE count=3, device words 11,22,33 -> memory 1FFFE=11, 1FFFF=22, 00000=33, mem_wr_en=1111 on exactly 3 cycles.
REQ-026 dev_out_ready=0 for 20 cycles during 8-word fetch -> exactly FIFO_DEPTH fetches issued then stall; release -> all 8 words in order, none lost or duplicated.
REQ-027 sio count=0 -> cc=0100, running stays 0; second sio while running -> cc=1000, first transfer completes correctly.
REQ-028 IOC_HALT_EN defined, hio after 2 of 6 stored words -> exactly 2 words written, cc=0010, running=0; reset=0 mid-fetch -> all outputs 0 next cycle.
